// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states
// and datapath mux select values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that sit on the memory handshake and are covered by the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Saturating memory wait counter; flags the wait cycle that exhausts the
// MEM_TIMEOUT budget so the FSM can trap instead of holding.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX   = '1;
  localparam bit                   ENABLED   = (MEM_TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = ENABLED ? TIMEOUT_W'(MEM_TIMEOUT - 1) : '0;

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // The wait that would bring the count to MEM_TIMEOUT is the last one allowed.
  assign expire = ENABLED && inc && (count_q == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath (R-type, lw, sw, beq, j)
// with memory-ready handshake, sticky illegal-opcode and bus-timeout traps.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Illegal,
  output logic       BusErr,
  output logic [3:0] State
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   wait_inc, wait_clear, wait_expire;

  assign wait_inc   = is_wait_state(state_q) && !MemReady;
  assign wait_clear = is_wait_state(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TIMEOUT_W  (TIMEOUT_W)
  ) u_wait_timer (
    .clk   (Clk),
    .rst_n (ResetN),
    .clear (wait_clear),
    .inc   (wait_inc),
    .expire(wait_expire)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (wait_expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (Opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_MEMRD: begin
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (wait_expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (wait_expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_EXEC:  state_d = S_RTYPEWB;
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Reset gates the whole decode so nothing is asserted in a reset cycle.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;
    BusErr      = 1'b0;
    State       = S_FETCH;
    if (ResetN) begin
      Illegal = illegal_q;
      BusErr  = bus_err_q;
      State   = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH2;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          MemtoReg  = 1'b1;
          InstrDone = 1'b1;
        end
        S_MEMWR: begin
          MemWrite  = 1'b1;
          IorD      = 1'b1;
          InstrDone = MemReady;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          RegWrite  = 1'b1;
          RegDst    = 1'b1;
          InstrDone = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          InstrDone   = 1'b1;
        end
        S_JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = PCSRC_JUMP;
          InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors are queued
// by the stimulus process and checked by a negedge monitor.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       ResetN, MemReady;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, Illegal, BusErr;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  always #5 Clk = ~Clk;

  multicycle_control #(.MEM_TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .Clk(Clk), .ResetN(ResetN), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .InstrDone(InstrDone), .Illegal(Illegal),
    .BusErr(BusErr), .State(State)
  );

  // Control vector: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
  // RegDst RegWrite ALUSrcA | ALUSrcB | ALUOp | PCSource | InstrDone
  localparam logic [16:0] C_ZERO = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] C_FW   = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] C_FR   = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] C_DEC  = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_MA   = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MR   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] C_WB   = 17'b0000001010_00_00_00_1;
  localparam logic [16:0] C_MWW  = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_MWR  = 17'b0010100000_00_00_00_1;
  localparam logic [16:0] C_EX   = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] C_RW   = 17'b0000000110_00_00_00_1;
  localparam logic [16:0] C_BR   = 17'b0100000001_00_01_01_1;
  localparam logic [16:0] C_J    = 17'b1000000000_00_00_10_1;

  typedef struct {
    string       lbl;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic        be;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  cur;
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic [16:0] act_ctl;

  assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone};

  always @(negedge Clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      n_cmp++;
      if ({State, act_ctl, Illegal, BusErr} !== {cur.st, cur.ctl, cur.ill, cur.be}) begin
        n_fail++;
        $display("FAIL %s: got st=%0d ctl=%b ill=%b be=%b, want st=%0d ctl=%b ill=%b be=%b",
                 cur.lbl, State, act_ctl, Illegal, BusErr, cur.st, cur.ctl, cur.ill, cur.be);
      end
    end
  end

  task automatic chk_now(input string lbl, input logic [3:0] st, input logic [16:0] ctl,
                         input logic ill, input logic be);
    n_cmp++;
    if ({State, act_ctl, Illegal, BusErr} !== {st, ctl, ill, be}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ctl=%b ill=%b be=%b, want st=%0d ctl=%b ill=%b be=%b",
               lbl, State, act_ctl, Illegal, BusErr, st, ctl, ill, be);
    end else begin
      $display("PASS %s: st=%0d ctl=%b ill=%b be=%b", lbl, State, act_ctl, Illegal, BusErr);
    end
  endtask

  task automatic cyc(input string lbl, input logic rn, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [16:0] ctl, input logic ill, input logic be);
    exp_t e;
    ResetN   = rn;
    Opcode   = op;
    MemReady = rdy;
    e.lbl = lbl; e.st = st; e.ctl = ctl; e.ill = ill; e.be = be;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN = 1'b0; Opcode = 6'd0; MemReady = 1'b0;
    @(posedge Clk);
    #1;

    $display("txn reset");
    for (int i = 0; i < 2; i++) cyc("reset", 1'b0, 6'($urandom), 1'($urandom), 4'd0, C_ZERO, 1'b0, 1'b0);
    chk_now("reset_state", 4'd0, C_ZERO, 1'b0, 1'b0);

    $display("txn rtype zero-wait");
    cyc("r_fetch",  1'b1, OP_RTYPE, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("r_decode", 1'b1, OP_RTYPE, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("r_exec",   1'b1, OP_RTYPE, 1'b1, 4'd6, C_EX,  1'b0, 1'b0);
    cyc("r_wb",     1'b1, OP_RTYPE, 1'b1, 4'd7, C_RW,  1'b0, 1'b0);

    $display("txn lw with 3 MEMRD waits");
    cyc("lw_fetch",  1'b1, OP_LW, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("lw_decode", 1'b1, OP_LW, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("lw_memadr", 1'b1, OP_LW, 1'b1, 4'd2, C_MA,  1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b1, OP_LW, 1'b0, 4'd3, C_MR, 1'b0, 1'b0);
    cyc("lw_memrd_rdy", 1'b1, OP_LW, 1'b1, 4'd3, C_MR, 1'b0, 1'b0);
    cyc("lw_memwb",     1'b1, OP_LW, 1'b1, 4'd4, C_WB, 1'b0, 1'b0);

    $display("txn beq");
    cyc("beq_fetch",  1'b1, OP_BEQ, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("beq_decode", 1'b1, OP_BEQ, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("beq_branch", 1'b1, OP_BEQ, 1'b1, 4'd8, C_BR,  1'b0, 1'b0);

    $display("txn j");
    cyc("j_fetch",  1'b1, OP_J, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("j_decode", 1'b1, OP_J, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("j_jump",   1'b1, OP_J, 1'b1, 4'd9, C_J,   1'b0, 1'b0);

    $display("txn sw with 1 MEMWR wait");
    cyc("sw_fetch",     1'b1, OP_SW, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("sw_decode",    1'b1, OP_SW, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("sw_memadr",    1'b1, OP_SW, 1'b1, 4'd2, C_MA,  1'b0, 1'b0);
    cyc("sw_memwr_wait", 1'b1, OP_SW, 1'b0, 4'd5, C_MWW, 1'b0, 1'b0);
    cyc("sw_memwr_rdy", 1'b1, OP_SW, 1'b1, 4'd5, C_MWR, 1'b0, 1'b0);

    $display("txn illegal opcode");
    cyc("ill_fetch",  1'b1, 6'b111111, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("ill_decode", 1'b1, 6'b111111, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("ill_trap_hold", 1'b1, 6'($urandom), 1'($urandom), 4'd10, C_ZERO, 1'b1, 1'b0);
    cyc("ill_reset", 1'b0, OP_RTYPE, 1'b1, 4'd0, C_ZERO, 1'b0, 1'b0);

    $display("txn fetch timeout");
    for (int i = 0; i < 15; i++) cyc("to_fetch_wait", 1'b1, OP_LW, 1'b0, 4'd0, C_FW, 1'b0, 1'b0);
    chk_now("to_expired", 4'd10, C_ZERO, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("to_trap_hold", 1'b1, OP_LW, 1'($urandom), 4'd10, C_ZERO, 1'b0, 1'b1);
    cyc("to_reset", 1'b0, OP_LW, 1'b0, 4'd0, C_ZERO, 1'b0, 1'b0);

    $display("txn lw with ready on last allowed wait");
    for (int i = 0; i < 14; i++) cyc("late_fetch_wait", 1'b1, OP_LW, 1'b0, 4'd0, C_FW, 1'b0, 1'b0);
    cyc("late_fetch_rdy", 1'b1, OP_LW, 1'b1, 4'd0, C_FR,  1'b0, 1'b0);
    cyc("late_decode",    1'b1, OP_LW, 1'b1, 4'd1, C_DEC, 1'b0, 1'b0);
    cyc("late_memadr",    1'b1, OP_LW, 1'b1, 4'd2, C_MA,  1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc("late_memrd_wait", 1'b1, OP_LW, 1'b0, 4'd3, C_MR, 1'b0, 1'b0);
    cyc("late_memrd_rdy", 1'b1, OP_LW, 1'b1, 4'd3, C_MR, 1'b0, 1'b0);
    cyc("late_memwb",     1'b1, OP_LW, 1'b1, 4'd4, C_WB, 1'b0, 1'b0);
    cyc("late_next_fetch", 1'b1, OP_J, 1'b0, 4'd0, C_FW, 1'b0, 1'b0);

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath: shared instruction/data memory, single ALU, IR, A/B/ALUOut registers.
- Supports R-type, lw, sw, beq and j.
- Emits all per-cycle datapath enables and mux selects, and waits on a memory-ready handshake.
- Traps on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory state waits for MemReady before a bus-error trap; 0 disables the timeout.
- TIMEOUT_W, 4: width of the wait counter; must satisfy 2^TIMEOUT_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  rising-edge clock
- ResetN  in  1  synchronous active-low reset
- Opcode  in  6  IR[31:26]; sampled only in DECODE and MEMADR
- MemReady  in  1  memory completes the current read or write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 1 = MDR
- RegDst  out  1  destination select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct decode
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- InstrDone  out  1  high during the final cycle of each instruction
- Illegal  out  1  sticky: illegal opcode trap
- BusErr  out  1  sticky: memory timeout trap
- State  out  4  current state encoding, for debug

Behaviour:
- Reset: while ResetN = 0 at a Clk edge, State becomes FETCH, the wait counter and both sticky flags clear, and every output is forced to 0 in that cycle (reset gates the output decode). Reset mid-instruction abandons the instruction with no partial write beyond the cycle already completed.
- State encoding, shared via the package: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RTYPEWB = 7, BRANCH = 8, JUMP = 9, TRAP = 10. Encodings 11-15 go to TRAP with Illegal = 1.
- Outputs are a pure function of State and MemReady. Any output not listed for a state is 0.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite are asserted only in the cycle where MemReady = 1; that cycle moves to DECODE. Otherwise FETCH holds.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Next state: 000000 goes to EXEC; 100011 and 101011 go to MEMADR; 000100 goes to BRANCH; 000010 goes to JUMP.
  - Any other opcode goes to TRAP and sets Illegal.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: MemRead = 1, IorD = 1. MemReady moves to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, InstrDone = 1; then FETCH.
- MEMWR: MemWrite = 1, IorD = 1. InstrDone = MemReady; MemReady moves to FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; then RTYPEWB.
- RTYPEWB: RegWrite = 1, RegDst = 1, MemtoReg = 0, InstrDone = 1; then FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, InstrDone = 1; then FETCH.
- JUMP: PCWrite = 1, PCSource = 10, InstrDone = 1; then FETCH.
- TRAP: all datapath controls are 0 and the FSM stays in TRAP until reset. Illegal and BusErr hold their values.
- Latency with zero-wait memory (MemReady tied high): R-type 4 cycles, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle that state holds with MemReady = 0.
  - When it reaches MEM_TIMEOUT (MEM_TIMEOUT > 0), the next state is TRAP and BusErr is set.
  - MemReady arriving in the same cycle the count reaches MEM_TIMEOUT wins: the FSM proceeds normally.
  - The counter saturates and never wraps.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - the state encodings;
  - ALUOp, ALUSrcB and PCSource select constants.
- Sub-module mem_wait_timer (counter, clear, increment, timeout compare), parameterised by MEM_TIMEOUT and TIMEOUT_W.

Test Plan:
- ResetN = 0 for 2 cycles with random Opcode -> all outputs 0; after release State = 0, MemRead = 1.
- MemReady = 1, Opcode = 000000 -> states 0, 1, 6, 7, 0; RegWrite = 1 and RegDst = 1 only in cycle 4; InstrDone pulses once.
- Opcode = 100011, MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemtoReg = 1; total 8 cycles.
- Opcode = 000100, then 000010 -> BRANCH with PCWriteCond = 1, PCSource = 01 (3 cycles); JUMP with PCWrite = 1, PCSource = 10 (3 cycles).
- Opcode = 111111 in DECODE -> TRAP, Illegal = 1 and held for 20 cycles; ResetN pulse -> Illegal = 0, State = FETCH.
- MEM_TIMEOUT = 15, MemReady = 0 in FETCH -> BusErr = 1 after exactly 15 wait cycles; with MemReady = 1 on cycle 15 -> DECODE, BusErr = 0.
